sr_ff_sequencer: RTL
====================

SR_FF_SEQUENCER -- requirements
Module: sr_ff_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8, width of the per-step dwell count.
REQ-002 Parameter LOOP_W, default 4, width of the loop count.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to run a sequence; sampled only in IDLE.
REQ-006 dwell  input  DWELL_W  cycles per step; latched at start; 0 is treated as 1.
REQ-007 loops  input  LOOP_W  number of full pattern passes; latched at start; 0 is treated as 1.
REQ-008 s, r  output  1 each  registered set/reset drive to the flip-flop cell.
REQ-009 q, qbar  output  1 each  flip-flop cell outputs.
REQ-010 step  output  2  current step: 0=SET, 1=RST, 2=HOLD, 3=BOTH.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  single-cycle pulse at sequence end.
REQ-013 illegal  output  1  registered; high while the cell sees s=r=1.

Function
REQ-014 States: IDLE, SET (s=1,r=0), RST (s=0,r=1), HOLD (s=0,r=0), BOTH (s=1,r=1), DONE.
REQ-015 IDLE with start=1 -> SET on the next edge; dwell and loops latched on that same edge.
REQ-016 Each step lasts exactly max(dwell,1) cycles, then advances SET->RST->HOLD->BOTH.
REQ-017 After the last step of a pass: if the pass counter is below max(loops,1), go to SET and increment it; otherwise go to DONE.
REQ-018 DONE lasts one cycle, done=1, s=r=0, then IDLE; busy=0 in DONE.
REQ-019 start during any non-IDLE state is ignored, with no queuing.
REQ-020 Changes to dwell/loops while busy have no effect.
REQ-021 Cell: q updates one cycle after s/r; 10 -> q=1; 01 -> q=0; 00 -> hold; 11 -> hold, illegal=1 on the following cycle.
REQ-022 qbar is always ~q.
REQ-023 Dwell counter is DWELL_W bits and counts from 1 up to the effective dwell value, with no wrap at dwell=2^DWELL_W-1.
REQ-024 Pass counter is LOOP_W bits, with no wrap at loops=2^LOOP_W-1.

Reset
REQ-025 rst_n=0 immediately forces IDLE, s=0, r=0, q=0, qbar=1, step=0, busy=0, done=0, illegal=0, and clears all counters.
REQ-026 Reset mid-sequence aborts without a done pulse.
REQ-027 The first start is accepted on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro SR_ILLEGAL_STATE_EN.
REQ-029 With SR_ILLEGAL_STATE_EN defined, the pattern has 4 steps including BOTH.
REQ-030 Without SR_ILLEGAL_STATE_EN, BOTH is never entered: HOLD is the last step of a pass, and illegal is tied to 0.

Structure
REQ-031 Shared package holds the state enum, the step encodings (SET/RST/HOLD/BOTH), and default DWELL_W/LOOP_W constants.
REQ-032 One sub-module, sr_ff_cell: clocked SR flip-flop with async active-low reset, providing q/qbar/illegal; the sequencer instantiates it once.

Verification
REQ-033 Macro on, dwell=10, loops=1, start at cycle 0 -> s=1 cycles 1-10, r=1 cycles 11-20, s=r=0 cycles 21-30, s=r=1 cycles 31-40, done=1 at cycle 41, q=1 at cycle 2, q=0 at cycle 12, illegal=1 cycles 32-41.
REQ-034 Macro off, dwell=5, loops=3 -> three SET/RST/HOLD passes of 15 cycles each, done at cycle 46, illegal never 1.
REQ-035 dwell=0, loops=0 -> each step lasts 1 cycle, one pass, done follows the last step.
REQ-036 start re-pulsed at cycle 7 of a dwell=10 run, and dwell changed to 3 at the same time -> no effect on timing.
REQ-037 rst_n low at cycle 15 of a dwell=10 run -> all outputs take reset values asynchronously, no done pulse, next start runs normally.
REQ-038 dwell=255, loops=15 -> exact 255-cycle steps, 15 passes, no counter wrap.

Source files
------------

// File: rtl/sr_ff_sequencer_pkg.sv
// Purpose : shared types and constants for the SR flip-flop test-pattern sequencer.
// Latency : n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Contents: state enum, step encodings, default widths, state-to-drive helpers.
// Macro   : SR_ILLEGAL_STATE_EN (consumed by the sequencer and cell, not here).
package sr_ff_sequencer_pkg;

   localparam int DEFAULT_DWELL_W = 8;
   localparam int DEFAULT_LOOP_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET,
      ST_RST,
      ST_HOLD,
      ST_BOTH,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      STEP_SET  = 2'd0,
      STEP_RST  = 2'd1,
      STEP_HOLD = 2'd2,
      STEP_BOTH = 2'd3
   } step_t;

   // Step code reported on the step output; non-pattern states report SET (0).
   function automatic step_t step_of(input state_t st);
      step_t res;
      case (st)
         ST_RST:  res = STEP_RST;
         ST_HOLD: res = STEP_HOLD;
         ST_BOTH: res = STEP_BOTH;
         default: res = STEP_SET;
      endcase
      return res;
   endfunction

   // {s, r} drive applied to the cell while in a given state.
   function automatic logic [1:0] sr_of(input state_t st);
      logic [1:0] res;
      case (st)
         ST_SET:  res = 2'b10;
         ST_RST:  res = 2'b01;
         ST_BOTH: res = 2'b11;
         default: res = 2'b00;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// Purpose : clocked SR flip-flop cell driven by the sequencer.
// Latency : q and illegal follow s/r by one clock.
// Backpressure: none; inputs are sampled every cycle.
// Ports   : clk, rst_n (async active-low), s, r in; q, qbar, illegal out.
// Macro   : SR_ILLEGAL_STATE_EN enables the illegal (s=r=1) flag; otherwise it is tied low.
module sr_ff_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   input  logic r,
   output logic q,
   output logic qbar,
   output logic illegal
);

   // s=r=1 is treated as hold; the condition is only flagged, never resolved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({s, r})
            2'b10:   q <= 1'b1;
            2'b01:   q <= 1'b0;
            default: q <= q;
         endcase
      end
   end

   assign qbar = ~q;

`ifdef SR_ILLEGAL_STATE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else begin
         illegal <= s & r;
      end
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: rtl/sr_ff_sequencer.sv
// Purpose : steps an SR flip-flop cell through SET/RST/HOLD(/BOTH) passes with a per-step dwell.
// Latency : s/r/step/busy update on the edge that accepts start; done pulses one cycle after the last step.
// Backpressure: none; start is only honoured in IDLE and dropped (not queued) otherwise.
// Ports   : clk, rst_n, start, dwell[DWELL_W], loops[LOOP_W] in;
//           s, r, q, qbar, step[2], busy, done, illegal out.
// Macro   : SR_ILLEGAL_STATE_EN adds the BOTH (s=r=1) step as the last step of every pass.
module sr_ff_sequencer
   import sr_ff_sequencer_pkg::*;
#(
   parameter int DWELL_W = DEFAULT_DWELL_W,
   parameter int LOOP_W  = DEFAULT_LOOP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [LOOP_W-1:0]  loops,
   output logic               s,
   output logic               r,
   output logic               q,
   output logic               qbar,
   output logic [1:0]         step,
   output logic               busy,
   output logic               done,
   output logic               illegal
);

   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
   localparam logic [LOOP_W-1:0]  LOOP_ONE  = LOOP_W'(1);

   state_t             state;
   state_t             adv_state;
   logic [DWELL_W-1:0] dwell_lat;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [LOOP_W-1:0]  loops_lat;
   logic [LOOP_W-1:0]  pass_cnt;
   logic               step_end;
   logic               pass_more;

   // Both counters start at 1 and stop at the latched (already >= 1) limit,
   // so the all-ones limit is reached without ever wrapping.
   assign step_end  = (dwell_cnt == dwell_lat);
   assign pass_more = (pass_cnt < loops_lat);

   // State taken when the current step's dwell expires.
   always_comb begin
      adv_state = state;
      case (state)
         ST_SET:  adv_state = ST_RST;
         ST_RST:  adv_state = ST_HOLD;
`ifdef SR_ILLEGAL_STATE_EN
         ST_HOLD: adv_state = ST_BOTH;
`else
         ST_HOLD: adv_state = pass_more ? ST_SET : ST_DONE;
`endif
         ST_BOTH: adv_state = pass_more ? ST_SET : ST_DONE;
         default: adv_state = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         s         <= 1'b0;
         r         <= 1'b0;
         step      <= STEP_SET;
         busy      <= 1'b0;
         done      <= 1'b0;
         dwell_lat <= '0;
         dwell_cnt <= '0;
         loops_lat <= '0;
         pass_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= ST_SET;
                  s         <= 1'b1;
                  r         <= 1'b0;
                  step      <= STEP_SET;
                  busy      <= 1'b1;
                  dwell_cnt <= DWELL_ONE;
                  pass_cnt  <= LOOP_ONE;
                  // Zero requests are promoted to one so the compare logic never sees 0.
                  dwell_lat <= (dwell == '0) ? DWELL_ONE : dwell;
                  loops_lat <= (loops == '0) ? LOOP_ONE : loops;
               end
            end
            ST_SET, ST_RST, ST_HOLD, ST_BOTH: begin
               if (step_end) begin
                  state      <= adv_state;
                  {s, r}     <= sr_of(adv_state);
                  step       <= step_of(adv_state);
                  dwell_cnt  <= DWELL_ONE;
                  if (adv_state == ST_SET) begin
                     pass_cnt <= pass_cnt + LOOP_ONE;
                  end
                  if (adv_state == ST_DONE) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end else begin
                  dwell_cnt <= dwell_cnt + DWELL_ONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               s     <= 1'b0;
               r     <= 1'b0;
               step  <= STEP_SET;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   sr_ff_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s),
      .r       (r),
      .q       (q),
      .qbar    (qbar),
      .illegal (illegal)
   );

endmodule
